// File: rtl/cva6_rvfi_collector_if.sv
// Retire-port inputs and trace-record stream of the RVFI collector.
// Revision: 1.0
`default_nettype none

interface cva6_rvfi_collector_if #(
  parameter int NrCommitPorts = 2,
  parameter int XLEN          = 64
);
  localparam int TraceW = 16 + XLEN + 32 + 1 + XLEN + 5 + XLEN;

  logic [NrCommitPorts-1:0]           rvfi_valid_i;
  logic [NrCommitPorts-1:0][XLEN-1:0] rvfi_pc_i;
  logic [NrCommitPorts-1:0][31:0]     rvfi_insn_i;
  logic [NrCommitPorts-1:0]           rvfi_trap_i;
  logic [NrCommitPorts-1:0][XLEN-1:0] rvfi_cause_i;
  logic [NrCommitPorts-1:0][4:0]      rvfi_rd_addr_i;
  logic [NrCommitPorts-1:0][XLEN-1:0] rvfi_rd_wdata_i;
  logic                               trace_valid_o;
  logic                               trace_ready_i;
  logic [TraceW-1:0]                  trace_o;

  modport master (
    output rvfi_valid_i, rvfi_pc_i, rvfi_insn_i, rvfi_trap_i, rvfi_cause_i,
           rvfi_rd_addr_i, rvfi_rd_wdata_i, trace_ready_i,
    input  trace_valid_o, trace_o
  );

  modport slave (
    input  rvfi_valid_i, rvfi_pc_i, rvfi_insn_i, rvfi_trap_i, rvfi_cause_i,
           rvfi_rd_addr_i, rvfi_rd_wdata_i, trace_ready_i,
    output trace_valid_o, trace_o
  );
endinterface

`default_nettype wire

// File: rtl/cva6_rvfi_collector.sv
// Compacts multi-port RVFI retires into a sequence-tagged record FIFO.
// Revision: 1.0
`default_nettype none

module cva6_rvfi_collector #(
  parameter int NrCommitPorts = 2,
  parameter int XLEN          = 64,
  parameter int Depth         = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     clear_i,
  cva6_rvfi_collector_if.slave     bus,
  output logic                     overflow_o,
  output logic [15:0]              drop_cnt_o,
  output logic [$clog2(Depth):0]   level_o
);
  localparam int LW     = $clog2(Depth) + 1;
  localparam int PW     = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int TW     = 16 + XLEN + 32 + 1 + XLEN + 5 + XLEN;
  localparam int c_MASK = Depth - 1;

  logic [TW-1:0] r_mem [Depth];
  logic [PW-1:0] r_rptr;
  logic [PW-1:0] r_wptr;
  logic [LW-1:0] r_level;
  logic [15:0]   r_seq;
  logic [15:0]   r_drop;
  logic          r_overflow;

  logic          w_pop;
  logic [LW-1:0] w_free;
  logic [LW-1:0] w_nvalid;
  logic [LW-1:0] w_npush;
  logic [LW-1:0] w_ndrop;
  logic [LW-1:0] w_off [NrCommitPorts];
  logic [PW-1:0] w_idx [NrCommitPorts];
  logic [PW-1:0] w_rptr_nxt;
  logic [PW-1:0] w_wptr_nxt;
  logic [16:0]   w_drop_sum;

  // w_off[p] is the slot offset of port p after squeezing out invalid ports
  always_comb begin
    w_pop    = (r_level != '0) && bus.trace_ready_i;
    w_free   = LW'(Depth) - r_level + LW'(w_pop);
    w_nvalid = '0;
    for (int p = 0; p < NrCommitPorts; p++) begin
      w_off[p] = w_nvalid;
      w_idx[p] = PW'((int'(r_wptr) + int'(w_nvalid)) & c_MASK);
      if (bus.rvfi_valid_i[p]) begin
        w_nvalid = w_nvalid + LW'(1);
      end
    end
    w_npush    = (w_nvalid < w_free) ? w_nvalid : w_free;
    w_ndrop    = w_nvalid - w_npush;
    w_rptr_nxt = PW'((int'(r_rptr) + int'(w_pop)) & c_MASK);
    w_wptr_nxt = PW'((int'(r_wptr) + int'(w_npush)) & c_MASK);
    w_drop_sum = {1'b0, r_drop} + 17'(w_ndrop);
  end

  always_ff @(posedge clk_i) begin
    for (int p = 0; p < NrCommitPorts; p++) begin
      if (!clear_i && bus.rvfi_valid_i[p] && (w_off[p] < w_npush)) begin
        r_mem[w_idx[p]] <= {r_seq + 16'(w_off[p]),
                            bus.rvfi_pc_i[p],
                            bus.rvfi_insn_i[p],
                            bus.rvfi_trap_i[p],
                            bus.rvfi_cause_i[p],
                            bus.rvfi_rd_addr_i[p],
                            bus.rvfi_rd_wdata_i[p]};
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_rptr     <= '0;
      r_wptr     <= '0;
      r_level    <= '0;
      r_seq      <= '0;
      r_drop     <= '0;
      r_overflow <= 1'b0;
    end else if (clear_i) begin
      r_rptr     <= '0;
      r_wptr     <= '0;
      r_level    <= '0;
      r_seq      <= '0;
      r_drop     <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_rptr  <= w_rptr_nxt;
      r_wptr  <= w_wptr_nxt;
      r_level <= r_level + w_npush - LW'(w_pop);
      r_seq   <= r_seq + 16'(w_npush);
      if (w_ndrop != '0) begin
        r_overflow <= 1'b1;
        r_drop     <= w_drop_sum[16] ? 16'hFFFF : w_drop_sum[15:0];
      end
    end
  end

  // Empty FIFO presents zeros, which also covers the in-reset value
  assign bus.trace_valid_o = (r_level != '0);
  assign bus.trace_o       = (r_level != '0) ? r_mem[r_rptr] : '0;
  assign overflow_o        = r_overflow;
  assign drop_cnt_o        = r_drop;
  assign level_o           = r_level;

endmodule

`default_nettype wire

// File: tb/tb_cva6_rvfi_collector.sv
// Randomized bench for cva6_rvfi_collector against a queue-based record model.
// Revision: 1.0
`default_nettype none

module tb_cva6_rvfi_collector;
  localparam int NP = 2;
  localparam int XL = 64;
  localparam int DP = 8;
  localparam int TW = 16 + XL + 32 + 1 + XL + 5 + XL;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        clear = 1'b0;
  logic        ovf;
  logic [15:0] dcnt;
  logic [3:0]  lvl;

  cva6_rvfi_collector_if #(.NrCommitPorts(NP), .XLEN(XL)) bus ();

  cva6_rvfi_collector #(.NrCommitPorts(NP), .XLEN(XL), .Depth(DP)) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .clear_i    (clear),
    .bus        (bus),
    .overflow_o (ovf),
    .drop_cnt_o (dcnt),
    .level_o    (lvl)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [XL-1:0] s_pc    [NP];
  logic [31:0]   s_insn  [NP];
  logic          s_trap  [NP];
  logic [XL-1:0] s_cause [NP];
  logic [4:0]    s_rd    [NP];
  logic [XL-1:0] s_wd    [NP];

  logic [TW-1:0] mq[$];
  int            mseq;
  bit            movf;
  int            mdrop;

  task automatic check_val(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic rand_ports();
    for (int p = 0; p < NP; p++) begin
      s_pc[p]    = {$urandom, $urandom};
      s_insn[p]  = $urandom;
      s_trap[p]  = 1'($urandom_range(0, 1));
      s_cause[p] = {$urandom, $urandom};
      s_rd[p]    = 5'($urandom_range(0, 31));
      s_wd[p]    = {$urandom, $urandom};
    end
  endtask

  task automatic drive_ports();
    for (int p = 0; p < NP; p++) begin
      bus.rvfi_pc_i[p]       = s_pc[p];
      bus.rvfi_insn_i[p]     = s_insn[p];
      bus.rvfi_trap_i[p]     = s_trap[p];
      bus.rvfi_cause_i[p]    = s_cause[p];
      bus.rvfi_rd_addr_i[p]  = s_rd[p];
      bus.rvfi_rd_wdata_i[p] = s_wd[p];
    end
  endtask

  task automatic model_reset();
    mq.delete();
    mseq  = 0;
    movf  = 0;
    mdrop = 0;
  endtask

  // One clock of behaviour: pop first, then accept valid ports in order while room remains
  task automatic model_step(input logic [NP-1:0] v, input logic rdy, input logic clr);
    if (clr) begin
      model_reset();
    end else begin
      if (mq.size() > 0 && rdy) void'(mq.pop_front());
      for (int p = 0; p < NP; p++) begin
        if (v[p]) begin
          if (mq.size() < DP) begin
            mq.push_back({16'(mseq), s_pc[p], s_insn[p], s_trap[p], s_cause[p], s_rd[p], s_wd[p]});
            mseq = (mseq + 1) % 65536;
          end else begin
            movf = 1;
            if (mdrop < 65535) mdrop++;
          end
        end
      end
    end
  endtask

  task automatic check_all(input string tag);
    check_val({tag, " valid"}, bus.trace_valid_o, (mq.size() != 0));
    check_val({tag, " level"}, lvl, mq.size());
    check_val({tag, " ovf"}, ovf, movf);
    check_val({tag, " drop"}, dcnt, mdrop);
    if (mq.size() != 0) check_val({tag, " rec"}, bus.trace_o, mq[0]);
  endtask

  task automatic cycle(input string tag, input logic [NP-1:0] v, input logic rdy, input logic clr);
    drive_ports();
    bus.rvfi_valid_i  = v;
    bus.trace_ready_i = rdy;
    clear             = clr;
    model_step(v, rdy, clr);
    @(posedge clk);
    @(negedge clk);
    check_all(tag);
  endtask

  initial begin
    bus.rvfi_valid_i  = '0;
    bus.trace_ready_i = 1'b0;
    rand_ports();
    drive_ports();
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_val("rst valid", bus.trace_valid_o, 1'b0);
    check_val("rst level", lvl, 4'd0);
    check_val("rst trace", bus.trace_o, '0);
    check_val("rst drop", dcnt, 16'd0);
    rst = 1'b0;

    // Dual retire, then drain in order
    for (int p = 0; p < NP; p++) s_trap[p] = 1'b0;
    s_pc[0] = 64'h8000_0000;
    s_pc[1] = 64'h8000_0004;
    cycle("dual0", 2'b11, 1'b1, 1'b0);
    check_val("dual0 seq", bus.trace_o[TW-1 -: 16], 16'd0);
    check_val("dual0 pc", bus.trace_o[TW-17 -: XL], 64'h8000_0000);
    cycle("dual1", 2'b00, 1'b1, 1'b0);
    check_val("dual1 seq", bus.trace_o[TW-1 -: 16], 16'd1);
    check_val("dual1 pc", bus.trace_o[TW-17 -: XL], 64'h8000_0004);
    cycle("dual2", 2'b00, 1'b1, 1'b0);

    // Single trapping retire on the upper port
    rand_ports();
    s_trap[1]  = 1'b1;
    s_cause[1] = 64'd8;
    cycle("trap0", 2'b10, 1'b1, 1'b0);
    check_val("trap lvl", lvl, 4'd1);
    check_val("trap bit", bus.trace_o[TW-17-XL-32], 1'b1);
    check_val("trap cause", bus.trace_o[TW-18-XL-32 -: XL], 64'd8);
    cycle("trap1", 2'b00, 1'b1, 1'b0);

    // Fill with consumer stalled, overflow on the fifth cycle
    for (int i = 0; i < 5; i++) begin
      rand_ports();
      cycle("fill", 2'b11, 1'b0, 1'b0);
    end
    check_val("fill lvl", lvl, 4'd8);
    check_val("fill ovf", ovf, 1'b1);
    check_val("fill drop", dcnt, 16'd2);

    // Full with pop and two pushes: one in, one dropped
    rand_ports();
    cycle("fullpop", 2'b11, 1'b1, 1'b0);
    check_val("fullpop lvl", lvl, 4'd8);
    check_val("fullpop drop", dcnt, 16'd3);
    for (int i = 0; i < 9; i++) cycle("drain", 2'b00, 1'b1, 1'b0);

    // Clear at level 5 with a concurrent push
    rand_ports();
    cycle("pre5a", 2'b11, 1'b0, 1'b0);
    rand_ports();
    cycle("pre5b", 2'b11, 1'b0, 1'b0);
    rand_ports();
    cycle("pre5c", 2'b01, 1'b0, 1'b0);
    check_val("pre5 lvl", lvl, 4'd5);
    rand_ports();
    cycle("clr", 2'b11, 1'b1, 1'b1);
    check_val("clr lvl", lvl, 4'd0);
    check_val("clr ovf", ovf, 1'b0);
    check_val("clr drop", dcnt, 16'd0);
    rand_ports();
    cycle("postclr", 2'b01, 1'b1, 1'b0);
    check_val("postclr seq", bus.trace_o[TW-1 -: 16], 16'd0);

    // Asynchronous reset mid-transfer
    rand_ports();
    cycle("prerst", 2'b11, 1'b0, 1'b0);
    #2 rst = 1'b1;
    #1;
    check_val("arst valid", bus.trace_valid_o, 1'b0);
    check_val("arst level", lvl, 4'd0);
    check_val("arst trace", bus.trace_o, '0);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check_all("relrst");
    rand_ports();
    cycle("firstpush", 2'b11, 1'b1, 1'b0);
    check_val("firstpush seq", bus.trace_o[TW-1 -: 16], 16'd0);

    // Randomized traffic: stalled phase then flowing phase
    for (int i = 0; i < 400; i++) begin
      logic [NP-1:0] v;
      logic          rdy;
      logic          clr;
      rand_ports();
      v   = NP'($urandom);
      rdy = (i < 200) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      clr = ($urandom_range(0, 49) == 0);
      cycle("rand", v, rdy, clr);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/cva6_rvfi_collector.md
CVA6_RVFI_COLLECTOR -- requirements
Module: cva6_rvfi_collector

Interface
REQ-001 SHALL have parameter NrCommitPorts, default 2: number of retire ports consumed per cycle (1..4).
REQ-002 SHALL have parameter XLEN, default 64: width of pc, rd_wdata and cause.
REQ-003 SHALL have parameter Depth, default 8: record FIFO entries, power of two, at least NrCommitPorts.
REQ-004 SHALL have port clk_i, input, 1: the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_i, input, 1: asynchronous reset, active-high.
REQ-006 SHALL have port clear_i, input, 1: synchronous flush of FIFO, flags and counters.
REQ-007 SHALL have port rvfi_valid_i, input, NrCommitPorts: per-port retire valid.
REQ-008 SHALL have port rvfi_pc_i, input, NrCommitPorts x XLEN: retired pc per port.
REQ-009 SHALL have port rvfi_insn_i, input, NrCommitPorts x 32: instruction word per port.
REQ-010 SHALL have port rvfi_trap_i, input, NrCommitPorts: trap flag per port.
REQ-011 SHALL have port rvfi_cause_i, input, NrCommitPorts x XLEN: trap cause per port.
REQ-012 SHALL have port rvfi_rd_addr_i, input, NrCommitPorts x 5: destination register per port.
REQ-013 SHALL have port rvfi_rd_wdata_i, input, NrCommitPorts x XLEN: destination write data per port.
REQ-014 SHALL have port trace_valid_o, input-side name inverted, output, 1: a record is presented.
REQ-015 SHALL have port trace_ready_i, input, 1: the consumer accepts the presented record.
REQ-016 SHALL have port trace_o, output, 16+XLEN+32+1+XLEN+5+XLEN bits, packed {seq, pc, insn, trap, cause, rd_addr, rd_wdata}.
REQ-017 SHALL have port overflow_o, output, 1: sticky, set when any record was dropped.
REQ-018 SHALL have port drop_cnt_o, output, 16: count of dropped records, saturating at 16'hFFFF.
REQ-019 SHALL have port level_o, output, $clog2(Depth)+1: current FIFO occupancy.

Function
REQ-020 SHALL consume records each cycle in ascending port order for ports with rvfi_valid_i set, compacting gaps so that ports 0 and 2 valid produce two consecutive entries.
REQ-021 SHALL compute free space as Depth - level + pop, where pop = trace_valid_o && trace_ready_i in the same cycle.
REQ-022 SHALL, when there are more valid ports than free slots, push the lowest-ordered ports up to the free slots, drop the rest, set overflow_o, and add the dropped number to drop_cnt_o.
REQ-023 SHALL tag each pushed record with seq, a 16-bit counter incremented per pushed record, wrapping from FFFF to 0000; dropped records consume no seq value.
REQ-024 SHALL drive trace_valid_o = (level != 0) from registered state; trace_o is the entry at the read pointer, held stable while trace_valid_o && !trace_ready_i.
REQ-025 SHALL make a record pushed at edge N visible on trace_o no earlier than the cycle after edge N, with no combinational input-to-output bypass.
REQ-026 SHALL pop one record per handshake; simultaneous pop and push of k records SHALL update level by k-1.
REQ-027 SHALL wrap the read and write pointers modulo Depth.
REQ-028 SHALL, on clear_i, empty the FIFO, set seq to 0, clear overflow_o and drop_cnt_o, and discard same-cycle pushes and pops; discarded records SHALL NOT be counted as dropped.
REQ-029 SHALL not alter FIFO contents or level when rvfi_valid_i = 0 and no pop occurs.

Reset
REQ-030 SHALL, on rst_i assertion at any time including mid-transfer, immediately force trace_valid_o=0, level_o=0, overflow_o=0, drop_cnt_o=0, seq=0, and pointers=0.
REQ-031 SHALL have trace_o contents defined as all zero during reset; FIFO storage need not be reset.
REQ-032 SHALL accept pushes on the first rising edge after rst_i deasserts.

Verification
REQ-033 Bench SHALL reset and then apply rvfi_valid_i=2'b11 with pc 0x80000000/0x80000004 and trace_ready_i=1 -> two records appear on consecutive cycles starting next cycle, with seq 0 then 1 and matching pc values.
REQ-034 Bench SHALL apply rvfi_valid_i=2'b10 alone with trap=1 and cause=8 -> one record with trap=1 and cause=8, and level_o peaks at 1.
REQ-035 Bench SHALL hold trace_ready_i=0 with Depth=8 and push 2 records per cycle for 5 cycles -> level_o=8, overflow_o=1, drop_cnt_o=2, and the records that remain are the first 8 in order.
REQ-036 Bench SHALL make level=8, trace_ready_i=1 and 2 valid ports in the same cycle -> one pushed, one dropped, level stays 8, drop_cnt_o increments by 1.
REQ-037 Bench SHALL assert clear_i with level=5 while a push is also valid -> level_o=0, overflow_o=0, drop_cnt_o=0, and the next pushed record has seq 0.
REQ-038 Bench SHALL assert rst_i asynchronously while trace_valid_o=1 -> trace_valid_o falls before the next clock edge, and all counters read 0 after release.
